// File: rtl/mark_counter_body.sv
// mark_counter_body: one downstream mark of the Golomb ruler search.
// Owns a candidate position, steps it on request, and hands val+1 to the
// next mark. Reports exhaustion once stepping would leave too little room
// for the marks still to be placed below it.
module mark_counter_body #(
  parameter int WIDTH            = 9,
  parameter int REMAINING_MARKS  = 1,
  parameter int STEP_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [WIDTH-1:0]            startValue,
  input  logic                        advance,
  input  logic                        clear,
  input  logic [WIDTH-1:0]            maxLength,
  output logic [WIDTH-1:0]            val,
  output logic [WIDTH-1:0]            nextStartValue,
  output logic                        valid,
  output logic                        exhausted,
  output logic                        changed,
  output logic [STEP_COUNT_WIDTH-1:0] stepCount
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ACTIVE    = 2'd1;
  localparam logic [1:0] S_EXHAUSTED = 2'd2;

  // Reserved tail positions, widened by one bit so the subtraction can borrow.
  localparam logic [WIDTH:0] RESERVE = (WIDTH+1)'(REMAINING_MARKS);

  logic [1:0]     state;
  logic [WIDTH:0] limit;
  logic           underflow;
  logic           start_ok;
  logic           step_ok;

  // Last position this mark may occupy, and whether a load/step stays within it.
  // An underflowed limit admits nothing, so every load lands in EXHAUSTED.
  always_comb begin
    underflow = {1'b0, maxLength} < RESERVE;
    limit     = {1'b0, maxLength} - RESERVE;
    start_ok  = !underflow && ({1'b0, startValue} <= limit);
    step_ok   = !underflow && ({1'b0, val} < limit);
  end

  // Command handling: clear beats load beats advance; advance only acts in ACTIVE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      val       <= '0;
      stepCount <= '0;
      changed   <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      val       <= '0;
      stepCount <= '0;
      changed   <= 1'b0;
    end else if (load) begin
      // A reload of the current value still strobes changed so the
      // downstream mark restarts from our nextStartValue.
      state     <= start_ok ? S_ACTIVE : S_EXHAUSTED;
      val       <= startValue;
      stepCount <= '0;
      changed   <= 1'b1;
    end else begin
      case (state)
        S_ACTIVE: begin
          if (advance && step_ok) begin
            val       <= val + 1'b1;
            stepCount <= (&stepCount) ? stepCount : stepCount + 1'b1;
            changed   <= 1'b1;
          end else if (advance) begin
            // At the limit: hold val and count, just stop.
            state   <= S_EXHAUSTED;
            changed <= 1'b0;
          end else begin
            changed <= 1'b0;
          end
        end
        S_IDLE, S_EXHAUSTED: begin
          changed <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          val       <= '0;
          stepCount <= '0;
          changed   <= 1'b0;
        end
      endcase
    end
  end

  // State decode and the saturating hand-off to the next mark.
  always_comb begin
    valid          = (state == S_ACTIVE);
    exhausted      = (state == S_EXHAUSTED);
    nextStartValue = (&val) ? val : val + 1'b1;
  end

endmodule

// File: tb/tb_mark_counter_body.sv
// Bench for mark_counter_body: three instances (1, 3 and 0 reserved marks)
// share stimulus; each is compared every cycle against an integer model.
module tb_mark_counter_body;
  localparam int W  = 9;
  localparam int SW = 16;
  localparam int VMAX = (1 << W) - 1;
  localparam int CMAX = (1 << SW) - 1;
  localparam int M_IDLE = 0, M_ACT = 1, M_EXH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0, advance = 1'b0, clear = 1'b0;
  logic [W-1:0]  startValue = '0, maxLength = '0;
  logic [W-1:0]  val [3];
  logic [W-1:0]  nsv [3];
  logic          valid [3], exh [3], chg [3];
  logic [SW-1:0] sc [3];

  int rm [3] = '{1, 3, 0};
  int m_st [3], m_val [3], m_sc [3], m_ch [3];
  int vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  mark_counter_body #(.WIDTH(W), .REMAINING_MARKS(1), .STEP_COUNT_WIDTH(SW)) u_rm1 (
    .clock(clock), .reset(reset), .load(load), .startValue(startValue),
    .advance(advance), .clear(clear), .maxLength(maxLength), .val(val[0]),
    .nextStartValue(nsv[0]), .valid(valid[0]), .exhausted(exh[0]),
    .changed(chg[0]), .stepCount(sc[0]));

  mark_counter_body #(.WIDTH(W), .REMAINING_MARKS(3), .STEP_COUNT_WIDTH(SW)) u_rm3 (
    .clock(clock), .reset(reset), .load(load), .startValue(startValue),
    .advance(advance), .clear(clear), .maxLength(maxLength), .val(val[1]),
    .nextStartValue(nsv[1]), .valid(valid[1]), .exhausted(exh[1]),
    .changed(chg[1]), .stepCount(sc[1]));

  mark_counter_body #(.WIDTH(W), .REMAINING_MARKS(0), .STEP_COUNT_WIDTH(SW)) u_rm0 (
    .clock(clock), .reset(reset), .load(load), .startValue(startValue),
    .advance(advance), .clear(clear), .maxLength(maxLength), .val(val[2]),
    .nextStartValue(nsv[2]), .valid(valid[2]), .exhausted(exh[2]),
    .changed(chg[2]), .stepCount(sc[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = M_IDLE; m_val[k] = 0; m_sc[k] = 0; m_ch[k] = 0;
    end
  endtask

  // Rules applied with signed integer arithmetic: a negative limit is underflow.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int lim;
      lim = int'(maxLength) - rm[k];
      if (clear) begin
        m_st[k] = M_IDLE; m_val[k] = 0; m_sc[k] = 0; m_ch[k] = 0;
      end else if (load) begin
        m_val[k] = int'(startValue); m_sc[k] = 0; m_ch[k] = 1;
        m_st[k]  = (int'(startValue) <= lim) ? M_ACT : M_EXH;
      end else if (advance && m_st[k] == M_ACT) begin
        if (m_val[k] < lim) begin
          m_val[k]++; m_ch[k] = 1;
          if (m_sc[k] < CMAX) m_sc[k]++;
        end else begin
          m_st[k] = M_EXH; m_ch[k] = 0;
        end
      end else begin
        m_ch[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("val[%0d]", k), 32'(val[k]), m_val[k]);
      chk($sformatf("nsv[%0d]", k), 32'(nsv[k]), (m_val[k] >= VMAX) ? VMAX : m_val[k] + 1);
      chk($sformatf("valid[%0d]", k), 32'(valid[k]), (m_st[k] == M_ACT) ? 1 : 0);
      chk($sformatf("exh[%0d]", k), 32'(exh[k]), (m_st[k] == M_EXH) ? 1 : 0);
      chk($sformatf("chg[%0d]", k), 32'(chg[k]), m_ch[k]);
      chk($sformatf("sc[%0d]", k), 32'(sc[k]), m_sc[k]);
    end
  endtask

  // One clock: drive commands, let the edge sample them, check 1 time unit later.
  task automatic cyc(input bit ld, input bit adv, input bit clr, input int sv);
    load = ld; advance = adv; clear = clr; startValue = W'(sv);
    @(posedge clock);
    model_step();
    #1;
    check_all();
    load = 1'b0; advance = 1'b0; clear = 1'b0;
  endtask

  // maxLength only moves while every instance is IDLE.
  task automatic set_ml(input int ml);
    cyc(0, 0, 1, 0);
    maxLength = W'(ml);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("rst_nsv", 32'(nsv[0]), 1);

    // Load 1 against maxLength 6, step to the limit, then exhaust.
    set_ml(6);
    cyc(1, 0, 0, 1);
    chk("t2_val", 32'(val[0]), 1);
    chk("t2_chg", 32'(chg[0]), 1);
    repeat (4) cyc(0, 1, 0, 0);
    chk("t2_val5", 32'(val[0]), 5);
    chk("t2_sc4", 32'(sc[0]), 4);
    cyc(0, 1, 0, 0);
    chk("t2_exh", 32'(exh[0]), 1);
    chk("t2_val_hold", 32'(val[0]), 5);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Load beyond the limit goes straight to EXHAUSTED.
    cyc(1, 0, 0, 6);
    chk("t3_exh", 32'(exh[0]), 1);
    chk("t3_chg", 32'(chg[0]), 1);
    cyc(0, 0, 0, 0);

    // Underflowed limit (3 reserved, maxLength 2).
    set_ml(2);
    cyc(1, 0, 0, 0);
    chk("t4_exh_rm3", 32'(exh[1]), 1);
    cyc(0, 1, 0, 0);

    // Priority: load beats advance, clear beats load; same-value reload strobes.
    set_ml(6);
    cyc(1, 0, 0, 2);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 3);
    chk("t5_val3", 32'(val[0]), 3);
    chk("t5_sc0", 32'(sc[0]), 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 3);
    chk("t5_reload_chg", 32'(chg[0]), 1);
    cyc(1, 0, 1, 4);
    chk("t5_clr_val", 32'(val[0]), 0);
    chk("t5_clr_valid", 32'(valid[0]), 0);

    // Top of range with no reserve: saturating nextStartValue, async reset.
    set_ml(VMAX);
    cyc(1, 0, 0, VMAX - 1);
    cyc(0, 1, 0, 0);
    chk("t6_val511", 32'(val[2]), VMAX);
    chk("t6_nsv_sat", 32'(nsv[2]), VMAX);
    cyc(0, 1, 0, 0);
    chk("t6_exh", 32'(exh[2]), 1);
    cyc(1, 0, 0, 100);
    advance = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_val", 32'(val[2]), 0);
    check_all();
    advance = 1'b0;
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;
    cyc(1, 0, 0, 4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r, ml, sv;
      r  = $urandom_range(0, 99);
      ml = int'(maxLength);
      sv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, VMAX)
                                       : $urandom_range(0, (ml + 2 > VMAX) ? VMAX : ml + 2);
      if (r < 3)       set_ml($urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(0, VMAX));
      else if (r < 20) cyc(1, 0, 0, sv);
      else if (r < 80) cyc(0, 1, 0, 0);
      else if (r < 85) cyc(1, 1, 0, sv);
      else if (r < 88) cyc(1, 0, 1, sv);
      else if (r < 90) cyc(0, 1, 1, 0);
      else             cyc(0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mark_counter_body.md
Name: mark_counter_body

Overview:
- Downstream stage of the ruler's head mark. Instantiated once for each non-zero mark of the Golomb ruler.
- Takes the upstream stage's nextStartValue as its load value and owns one candidate position.
- Steps that position on request from the search controller.
- Drives its own nextStartValue to the next mark downstream.
- Declares itself exhausted when stepping further would leave no room for the marks still to be placed below it.

Parameters:
- WIDTH, 9, position width; equals `PositionValueBitMax+1.
- REMAINING_MARKS, 1, number of marks downstream of this one; reserves positions at the far end.
- STEP_COUNT_WIDTH, 16, width of the diagnostic advance counter.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- load  input  1  single-cycle pulse; capture startValue and (re)start the search from it.
- startValue  input  WIDTH  start position; wired to the upstream nextStartValue.
- advance  input  1  single-cycle pulse; step val by one.
- clear  input  1  single-cycle pulse; return to IDLE.
- maxLength  input  WIDTH  current ruler length bound; must be stable while the stage is ACTIVE.
- val  output  WIDTH  position currently owned; registered.
- nextStartValue  output  WIDTH  first value the downstream mark tries; val+1, saturating.
- valid  output  1  high in ACTIVE only.
- exhausted  output  1  high in EXHAUSTED only.
- changed  output  1  one-cycle strobe, one cycle after val takes a new value; triggers the downstream reload.
- stepCount  output  STEP_COUNT_WIDTH  number of accepted advances since the last load; saturating.

Behaviour:
- limit = maxLength - REMAINING_MARKS, computed at WIDTH+1 bits.
  - If maxLength < REMAINING_MARKS, limit is "underflow".
  - With an underflowed limit, every load goes straight to EXHAUSTED.
- Reset (reset=0, asynchronous):
  - state=IDLE, val=0, valid=0, exhausted=0, changed=0, stepCount=0.
  - nextStartValue therefore reads 1.
- Command priority per cycle: clear > load > advance. Lower-priority commands in the same cycle are ignored.
- IDLE:
  - advance is ignored.
  - load with startValue <= limit: next state ACTIVE, val=startValue, stepCount=0, changed=1 next cycle.
  - load with startValue > limit: next state EXHAUSTED, val=startValue, stepCount=0, changed=1.
- ACTIVE:
  - advance with val < limit: val=val+1, stepCount+1 (saturating at all-ones), changed=1.
  - advance with val == limit: next state EXHAUSTED, val unchanged, stepCount unchanged, changed=0.
  - load re-enters via the IDLE load rules, with the same comparison against limit.
  - clear: next state IDLE, val=0, stepCount=0, changed=0.
- EXHAUSTED:
  - advance is ignored.
  - load follows the IDLE load rules.
  - clear goes to IDLE.
- Latency: val, valid and exhausted update on the edge that samples the command. changed is asserted for exactly one cycle after that edge.
- nextStartValue is combinational from the registered val:
  - val+1 normally.
  - When val is all-ones, nextStartValue is all-ones (no wrap).
- A load of the same value as the current val still pulses changed.
- A reset asserted mid-operation overrides everything. The first command is accepted on the first edge after reset is released.
- Values outside the encoded states (one-hot or binary) recover to IDLE.

Test Plan:
- Reset, then release; no commands -> val=0, nextStartValue=1, valid=0, exhausted=0, changed=0.
- REMAINING_MARKS=1, maxLength=6; load startValue=1 -> next cycle val=1, valid=1, changed=1 for one cycle. Then 4 advances -> val=5, stepCount=4. A 5th advance -> val=5, exhausted=1, valid=0, stepCount=4.
- maxLength=6, REMAINING_MARKS=1; load startValue=6 -> EXHAUSTED immediately, val=6, changed=1.
- REMAINING_MARKS=3, maxLength=2 (underflow); load startValue=0 -> exhausted=1.
- Same cycle load=1, advance=1, startValue=3 while ACTIVE at val=2 -> val=3, stepCount=0. Same cycle clear=1 and load=1 -> IDLE, val=0.
- WIDTH=9, maxLength=511, REMAINING_MARKS=0; load 510, advance -> val=511, nextStartValue=511 (saturated). Assert reset mid-advance -> val=0 immediately, without waiting for a clock edge.
